// File: rtl/adc0808_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc0808_scan_sequencer
//
// Purpose:
//   Drives an ADC0808 through the channels enabled in chan_mask in round-robin
//   order. For each channel it presents the address, pulses ALE/START, waits for
//   EOC to fall and rise again, enables the output drivers, and captures the
//   conversion into a per-channel result bank.
//
// Optional feature (compile-time macro ADC_SEQ_WDOG_EN):
//   When the macro is defined, each EOC wait phase is bounded by TIMEOUT_CYC
//   cycles. Expiry sets the sticky timeout_err flag and skips the capture.
//   Without the macro the waits are unbounded and timeout_err is tied low.
//
// Ports:
//   clk            sequencer clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         1 = keep scanning; 0 = finish current conversion then idle
//   chan_mask[7:0] bit i includes channel i in the scan
//   eoc            ADC end-of-conversion pin (asynchronous, synchronised here)
//   data_in[7:0]   ADC data bus
//   addr[2:0]      ADC channel address (ADD C..A)
//   ale, start     address latch enable / conversion start (pulsed together)
//   oe             ADC output enable
//   rd_sel[2:0]    result bank read select
//   rd_data[7:0]   result[rd_sel] (combinational read of registered bank)
//   rd_valid       valid[rd_sel]
//   sample_strobe  one-cycle pulse after each capture
//   sample_chan    channel of latest capture
//   sample_data    value of latest capture
//   busy           high whenever the sequencer is not idle
//   timeout_err    sticky watchdog flag (always 0 without ADC_SEQ_WDOG_EN)
// -----------------------------------------------------------------------------
module adc0808_scan_sequencer #(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 2,
    parameter int OE_CYC      = 2,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] chan_mask,
    input  logic       eoc,
    input  logic [7:0] data_in,
    output logic [2:0] addr,
    output logic       ale,
    output logic       start,
    output logic       oe,
    input  logic [2:0] rd_sel,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       sample_strobe,
    output logic [2:0] sample_chan,
    output logic [7:0] sample_data,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_PULSE, S_WAIT_LO, S_WAIT_HI, S_READ, S_NEXT
    } state_t;

    // The shared dwell counter is sized for the longest dwell it may hold.
    localparam int MAX_AB    = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_ABC   = (MAX_AB > OE_CYC) ? MAX_AB : OE_CYC;
    localparam int MAX_DWELL = (MAX_ABC > TIMEOUT_CYC) ? MAX_ABC : TIMEOUT_CYC;
    localparam int CNT_W     = $clog2(MAX_DWELL + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] OE_LAST    = CNT_W'(OE_CYC - 1);
`ifdef ADC_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_eoc_meta, r_eoc_s;
    logic [2:0]       r_ptr, r_addr;
    logic [7:0]       r_result [8];
    logic [7:0]       r_valid;
    logic             r_strobe;
    logic [2:0]       r_sample_chan;
    logic [7:0]       r_sample_data;
    logic [2:0]       w_next_chan;
    logic             w_go, w_load, w_capture, w_timeout;

    assign w_go = enable && (chan_mask != 8'h00);

    // Lowest enabled channel strictly above the pointer, wrapping 7 -> 0.
    // With a single enabled channel the search lands back on the pointer.
    always_comb begin : next_chan_search
        logic found;
        logic [2:0] cand;
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        found       = 1'b0;
        cand        = r_ptr;
        w_next_chan = r_ptr;
        for (int k = 1; k <= 8; k++) begin
            cand = 3'(int'(r_ptr) + k);
            if (!found && chan_mask[cand]) begin
                w_next_chan = cand;
                found       = 1'b1;
            end
        end
    end

    // Next-state logic. Mask and enable only matter in IDLE and NEXT.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_go) begin
                    w_state_nxt = S_SEL;
                    w_load      = 1'b1;
                end
            end
            S_SEL: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = '0;
                end
            end
            S_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = S_WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LO: begin
                if (!r_eoc_s) begin
                    w_state_nxt = S_WAIT_HI;
                    w_cnt_nxt   = '0;
                end
`ifdef ADC_SEQ_WDOG_EN
                else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = S_NEXT;
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                end
`endif
            end
            S_WAIT_HI: begin
                if (r_eoc_s) begin
                    w_state_nxt = S_READ;
                    w_cnt_nxt   = '0;
                end
`ifdef ADC_SEQ_WDOG_EN
                else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = S_NEXT;
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                end
`endif
            end
            S_READ: begin
                if (r_cnt == OE_LAST) begin
                    w_state_nxt = S_NEXT;
                    w_cnt_nxt   = '0;
                    w_capture   = 1'b1;
                end
            end
            S_NEXT: begin
                w_cnt_nxt = '0;
                if (w_go) begin
                    w_state_nxt = S_SEL;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eoc_meta    <= 1'b1;
            r_eoc_s       <= 1'b1;
            r_ptr         <= 3'd7;  // first scan starts at the lowest set bit
            r_addr        <= 3'd0;
            // NOTE: the result bank is a small register file that must read
            // 0x00 after reset, so it is reset like ordinary flops.
            for (int i = 0; i < 8; i++) r_result[i] <= 8'h00;
            r_valid       <= 8'h00;
            r_strobe      <= 1'b0;
            r_sample_chan <= 3'd0;
            r_sample_data <= 8'h00;
        end else begin
            r_eoc_meta <= eoc;
            r_eoc_s    <= r_eoc_meta;
            r_strobe   <= w_capture;
            if (w_load) begin
                r_ptr  <= w_next_chan;
                r_addr <= w_next_chan;
            end
            if (w_capture) begin
                r_result[r_ptr] <= data_in;
                r_valid[r_ptr]  <= 1'b1;
                r_sample_chan   <= r_ptr;
                r_sample_data   <= data_in;
            end
        end
    end

`ifdef ADC_SEQ_WDOG_EN
    logic r_timeout_err;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_timeout_err <= 1'b0;
        else if (w_timeout) r_timeout_err <= 1'b1;
    end
    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = w_timeout;
    assign timeout_err      = 1'b0;
`endif

    assign addr          = r_addr;
    assign ale           = (r_state == S_PULSE);
    assign start         = (r_state == S_PULSE);
    assign oe            = (r_state == S_READ);
    assign busy          = (r_state != S_IDLE);
    assign rd_data       = r_result[rd_sel];
    assign rd_valid      = r_valid[rd_sel];
    assign sample_strobe = r_strobe;
    assign sample_chan   = r_sample_chan;
    assign sample_data   = r_sample_data;

endmodule

// File: tb/tb_adc0808_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc0808_scan_sequencer
//
// Purpose:
//   Self-checking bench for adc0808_scan_sequencer. A behavioural ADC model
//   answers ALE/START with an EOC low pulse and supplies data; a reference
//   round-robin model predicts the channel of every conversion and pushes the
//   expected capture into a queue that an independent monitor pops on each
//   sample_strobe. Also checks pulse widths, idle behaviour, enable drop,
//   reset mid-read and, with ADC_SEQ_WDOG_EN defined, the watchdog.
// -----------------------------------------------------------------------------
module tb_adc0808_scan_sequencer;

    localparam int SETUP_CYC   = 2;
    localparam int PULSE_CYC   = 2;
    localparam int OE_CYC      = 2;
    localparam int TIMEOUT_CYC = 16;

    typedef struct {
        logic [2:0] chan;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] chan_mask = 8'h00;
    logic       eoc;
    logic [7:0] data_in;
    logic [2:0] rd_sel = 3'd0;
    logic [2:0] addr;
    logic       ale, start, oe, rd_valid, sample_strobe, busy, timeout_err;
    logic [7:0] rd_data, sample_data;
    logic [2:0] sample_chan;

    adc0808_scan_sequencer #(
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
        .OE_CYC(OE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .chan_mask(chan_mask),
        .eoc(eoc), .data_in(data_in), .addr(addr), .ale(ale), .start(start),
        .oe(oe), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
        .sample_strobe(sample_strobe), .sample_chan(sample_chan),
        .sample_data(sample_data), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_strobe = 0;
    int   n_start  = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [2:0] ref_ptr = 3'd7;
    logic [7:0] ref_result [8];
    logic       ref_valid  [8];

    // ADC model controls
    logic       fixed_data = 1'b0;
    logic [7:0] chan_data [8];
    int         conv_len = 20;
    logic       adc_stuck = 1'b0;
    logic       gap_check_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: lowest set mask bit strictly above p, wrapping.
    function automatic logic [2:0] ref_next(input logic [2:0] p, input logic [7:0] m);
        for (int k = 1; k <= 8; k++)
            if (m[(int'(p) + k) % 8]) return 3'((int'(p) + k) % 8);
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_ref();
        exp_q.delete();
        ref_ptr = 3'd7;
        for (int i = 0; i < 8; i++) begin
            ref_result[i] = 8'h00;
            ref_valid[i]  = 1'b0;
        end
    endtask

    task automatic apply_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        clear_ref();
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_strobes(input int target, input int budget, input string what);
        int c = 0;
        while (n_strobe < target && c < budget) begin
            tick(1);
            c++;
        end
        check(what, 32'(n_strobe >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    task automatic sweep();
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            check("rd_valid", 32'(rd_valid), 32'(ref_valid[i]));
            check("rd_data", 32'(rd_data), 32'(ref_result[i]));
        end
    endtask

    // Behavioural ADC0808: EOC falls 3 cycles after START falls and rises
    // conv_len cycles later. Each ALE rising edge is a new conversion whose
    // channel is predicted by the reference model.
    initial begin : adc_model
        int   dly_lo, dly_hi;
        logic p_ale, p_start;
        exp_t e;
        eoc = 1'b1; data_in = 8'h00;
        dly_lo = 0; dly_hi = 0; p_ale = 1'b0; p_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                eoc = 1'b1; dly_lo = 0; dly_hi = 0; p_ale = 1'b0; p_start = 1'b0;
            end else begin
                if (dly_lo > 0) begin
                    dly_lo--;
                    if (dly_lo == 0) begin
                        eoc = 1'b0;
                        dly_hi = conv_len;
                    end
                end else if (dly_hi > 0) begin
                    dly_hi--;
                    if (dly_hi == 0) eoc = 1'b1;
                end
                if (ale && !p_ale) begin
                    e.chan  = ref_next(ref_ptr, chan_mask);
                    ref_ptr = e.chan;
                    e.data  = fixed_data ? chan_data[e.chan] : 8'($urandom);
                    check("addr_at_ale", 32'(addr), 32'(e.chan));
                    if (!adc_stuck) begin
                        exp_q.push_back(e);
                        data_in = e.data;
                    end
                    n_start++;
                end
                if (p_start && !start && !adc_stuck) dly_lo = 3;
                p_ale = ale; p_start = start;
            end
        end
    end

    // Monitor: pops the scoreboard on each strobe and checks pulse timing.
    initial begin : monitor
        int   ale_w, st_w, oe_w, gap;
        logic p_ale, p_start, p_oe, counting, after_read;
        exp_t e;
        ale_w = 0; st_w = 0; oe_w = 0; gap = 0;
        p_ale = 0; p_start = 0; p_oe = 0; counting = 1; after_read = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ale_w = 0; st_w = 0; oe_w = 0; gap = 0;
                p_ale = 0; p_start = 0; p_oe = 0; counting = 1; after_read = 0;
            end else begin
                if (sample_strobe) begin
                    n_strobe++;
                    if (exp_q.size() == 0) begin
                        check("strobe_expected", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample_chan", 32'(sample_chan), 32'(e.chan));
                        check("sample_data", 32'(sample_data), 32'(e.data));
                        ref_result[e.chan] = e.data;
                        ref_valid[e.chan]  = 1'b1;
                    end
                end
                if (ale) ale_w++;
                else if (p_ale) begin check("ale_width", 32'(ale_w), PULSE_CYC); ale_w = 0; end
                if (start) st_w++;
                else if (p_start) begin check("start_width", 32'(st_w), PULSE_CYC); st_w = 0; end
                if (oe) oe_w++;
                else if (p_oe) begin check("oe_width", 32'(oe_w), OE_CYC); oe_w = 0; end
                // Address setup: SEL cycles before ALE, plus the NEXT cycle when
                // following a read.
                if (!busy) begin
                    gap = 0; counting = 1; after_read = 0;
                end else if (oe) begin
                    gap = 0; counting = 1; after_read = 1;
                end else if (ale) begin
                    if (!p_ale && gap_check_en)
                        check("setup_cycles", 32'(gap), after_read ? SETUP_CYC + 1 : SETUP_CYC);
                    counting = 0; after_read = 0; gap = 0;
                end else if (counting) begin
                    gap++;
                end
                p_ale = ale; p_start = start; p_oe = oe;
            end
        end
    end

    initial begin : global_timeout
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int base, viol, c, s0;
        for (int i = 0; i < 8; i++) chan_data[i] = 8'h00;
        clear_ref();

        // Reset state
        apply_reset();
        check("rst_addr", 32'(addr), 0);
        check("rst_ale", 32'(ale), 0);
        check("rst_start", 32'(start), 0);
        check("rst_oe", 32'(oe), 0);
        check("rst_strobe", 32'(sample_strobe), 0);
        check("rst_sample_chan", 32'(sample_chan), 0);
        check("rst_sample_data", 32'(sample_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        sweep();

        // Single channel 0, back-to-back
        fixed_data = 1'b1; chan_data[0] = 8'hA5; conv_len = 20;
        chan_mask = 8'h01; enable = 1'b1;
        wait_strobes(n_strobe + 2, 300, "single_chan_strobes");
        enable = 1'b0;
        wait_idle(200);
        sweep();
        rd_sel = 3'd0; #1;
        check("ch0_rd_data", 32'(rd_data), 32'hA5);
        check("ch0_rd_valid", 32'(rd_valid), 1);

        // Mask 0x85 from reset: order 0,2,7,0,2
        apply_reset();
        chan_data[0] = 8'h10; chan_data[2] = 8'h22; chan_data[7] = 8'h7F;
        chan_mask = 8'h85; enable = 1'b1;
        wait_strobes(n_strobe + 5, 600, "mask85_strobes");
        enable = 1'b0;
        wait_idle(200);
        sweep();
        rd_sel = 3'd2; #1; check("ch2_result", 32'(rd_data), 32'h22);
        rd_sel = 3'd7; #1; check("ch7_result", 32'(rd_data), 32'h7F);
        rd_sel = 3'd4; #1; check("ch4_invalid", 32'(rd_valid), 0);

        // Empty mask stays idle; then mask 0x08 selects channel 3
        fixed_data = 1'b0;
        chan_mask = 8'h00; enable = 1'b1;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (busy || ale || start || oe) viol++;
        end
        check("idle_quiet", 32'(viol), 0);
        chan_mask = 8'h08;
        wait_strobes(n_strobe + 1, 200, "mask08_strobe");
        check("mask08_chan", 32'(sample_chan), 3);
        enable = 1'b0;
        wait_idle(200);

        // Enable dropped during WAIT_HI on channel 4
        chan_mask = 8'h10; enable = 1'b1;
        c = 0;
        while (eoc && c < 200) begin tick(1); c++; end
        check("ch4_eoc_low", 32'(eoc), 0);
        tick(4);
        enable = 1'b0;
        base = n_strobe;
        wait_strobes(base + 1, 200, "ch4_capture");
        wait_idle(50);
        check("ch4_chan", 32'(sample_chan), 4);
        s0 = n_start;
        tick(100);
        check("no_start_after_drop", 32'(n_start), 32'(s0));
        check("idle_after_drop", 32'(busy), 0);

        // Randomized masks, data and conversion lengths
        for (int it = 0; it < 4; it++) begin
            chan_mask = 8'($urandom_range(1, 255));
            conv_len  = $urandom_range(4, 30);
            enable = 1'b1;
            wait_strobes(n_strobe + 6, 600, "rand_strobes");
            enable = 1'b0;
            wait_idle(200);
            sweep();
        end
        conv_len = 20;

        // Reset asserted during READ
        chan_mask = 8'hFF; enable = 1'b1;
        c = 0;
        while (!oe && c < 300) begin tick(1); c++; end
        check("reached_read", 32'(oe), 1);
        reset_n = 1'b0;
        clear_ref();
        #1;
        check("rst_read_oe", 32'(oe), 0);
        check("rst_read_busy", 32'(busy), 0);
        sweep();
        tick(2);
        reset_n = 1'b1;
        wait_strobes(n_strobe + 1, 200, "post_reset_strobe");
        check("post_reset_chan", 32'(sample_chan), 0);
        enable = 1'b0;
        wait_idle(200);

`ifdef ADC_SEQ_WDOG_EN
        // EOC stuck high: watchdog fires in WAIT_LO, no capture, addr advances
        apply_reset();
        gap_check_en = 1'b0; adc_stuck = 1'b1;
        base = n_strobe; s0 = n_start;
        chan_mask = 8'h03; enable = 1'b1;
        c = 0;
        while (!timeout_err && c < 200) begin tick(1); c++; end
        check("wdog_flag", 32'(timeout_err), 1);
        c = 0;
        while (n_start < s0 + 2 && c < 200) begin tick(1); c++; end
        check("wdog_advance", 32'(n_start >= s0 + 2), 1);
        enable = 1'b0;
        wait_idle(200);
        tick(10);
        check("wdog_no_strobe", 32'(n_strobe), 32'(base));
        check("wdog_sticky", 32'(timeout_err), 1);
        sweep();
        adc_stuck = 1'b0; gap_check_en = 1'b1;
`else
        check("timeout_err_tied", 32'(timeout_err), 0);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc0808_scan_sequencer.md
Name: adc0808_scan_sequencer

Overview:
Sequences the ADC0808 converter through a programmable set of analog channels in round-robin order. It drives the address, ALE, START and OE pins, tracks EOC, and captures each conversion into a per-channel result bank. Sits between the ADC pin interface (JA/JB) and downstream consumers such as the LED and BCD display logic. Replaces the single-channel, address-fixed-at-0 operation of the current interface.

Parameters:
SETUP_CYC, 2, clk cycles address is held stable before the ALE/START pulse (min 1)
PULSE_CYC, 2, clk cycles ALE and START are held high (min 1)
OE_CYC, 2, clk cycles OE is high before data capture (min 1)
TIMEOUT_CYC, 4095, watchdog limit per EOC wait phase (used only with the optional feature)

Ports:
clk  input  1  sequencer clock; rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = run scans; 0 = finish the current conversion, then idle
chan_mask  input  8  bit i = 1 includes channel i in the scan
eoc  input  1  ADC EOC pin; asynchronous; 2-flop synchronised internally to eoc_s
data_in  input  8  ADC D[7:0]
addr  output  3  ADC ADD C..A
ale  output  1  address latch enable
start  output  1  conversion start
oe  output  1  ADC output enable
rd_sel  input  3  result bank read select
rd_data  output  8  result[rd_sel]; combinational read of registered bank
rd_valid  output  1  valid[rd_sel]
sample_strobe  output  1  one-cycle pulse on each new capture
sample_chan  output  3  channel of latest capture
sample_data  output  8  value of latest capture
busy  output  1  1 whenever state != IDLE
timeout_err  output  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset (async, reset_n=0): state=IDLE. addr, ale, start, oe, sample_strobe, sample_chan, sample_data, busy and timeout_err all 0. All 8 results = 0x00, all valid = 0. Channel pointer = 7, so the first scan begins at the lowest set mask bit. Eoc sync flops = 1.
- States: IDLE, SEL, PULSE, WAIT_LO, WAIT_HI, READ, NEXT. One dwell counter is shared by the timed states.
- IDLE -> SEL when enable=1 and chan_mask!=0. On entry, addr = next channel: the lowest set mask bit strictly above the pointer, wrapping 7 -> 0. The pointer updates to that channel.
- SEL: ale=start=oe=0. Hold for SETUP_CYC cycles -> PULSE.
- PULSE: ale=start=1 for PULSE_CYC cycles -> WAIT_LO. Both fall together on exit.
- WAIT_LO: wait until eoc_s=0 -> WAIT_HI.
- WAIT_HI: wait until eoc_s=1 -> READ.
- READ: oe=1 for OE_CYC cycles. data_in is captured on the last READ cycle into result[ptr], and valid[ptr] is set. The next cycle brings sample_strobe=1 with sample_chan=ptr and sample_data=the captured value. sample_chan/sample_data hold until the next capture.
- NEXT (1 cycle, oe=0): if enable=1 and chan_mask!=0, go to SEL with the next channel; otherwise go to IDLE.
- addr is stable from SEL through READ.
- Mask and enable are sampled only in IDLE and NEXT. Changes mid-conversion take effect at the next selection. Clearing a channel's mask bit does not clear its result or valid bit.
- Single enabled channel: that channel converts back-to-back.
- enable falling mid-conversion: the conversion completes and is captured, then the block goes to IDLE.
- Read/capture collision on the same channel: rd_data shows the old value that cycle and the new value from the next cycle.
- Reset mid-operation: immediate return to reset values. Any in-flight conversion is discarded.

Optional Feature:
ADC_SEQ_WDOG_EN:
- With the macro defined: WAIT_LO and WAIT_HI each count cycles.
  - Reaching TIMEOUT_CYC sets timeout_err=1 (sticky until reset) and jumps to NEXT.
  - No capture occurs, and that channel's result and valid bit are unchanged.
  - The counter restarts on each wait state entry.
- Without the macro: waits are unbounded, timeout_err is tied to 0, and TIMEOUT_CYC is unused.

Test Plan:
- chan_mask=0x01, enable=1, EOC model (falls 3 cycles after START falls, rises 20 cycles later), data_in=0xA5 -> ale/start high exactly 2 cycles after 2 SEL cycles; oe high 2 cycles; sample_strobe with chan 0, data 0xA5; rd_sel=0 gives 0xA5, rd_valid=1.
- chan_mask=0x85, per-channel data 0x10/0x22/0x7F -> addr order 0,2,7,0,2; result[2]=0x22, result[7]=0x7F; rd_valid=0 for channels 1,3-6.
- chan_mask=0x00, enable=1 -> stays IDLE; busy=0, ale=start=oe=0 indefinitely. Then mask 0x08 -> first addr=3.
- enable dropped during WAIT_HI on channel 4 -> capture of channel 4 still occurs, then IDLE; no further START pulses.
- reset_n pulsed low during READ -> oe=0 immediately; all rd_valid=0, rd_data=0x00. Next scan with mask 0xFF starts at channel 0.
- ADC_SEQ_WDOG_EN, TIMEOUT_CYC=16, eoc held 1 with mask 0x03 -> after 16 WAIT_LO cycles timeout_err=1, no strobe, addr advances to 1; timeout_err remains 1 thereafter.
